// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I core: NOP encoding, reset PC and fetch FSM states.
package rv32_pkg;

    localparam logic [31:0] RV32_NOP      = 32'h0000_0013;
    localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/rv32_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it under stall, and drops it on flush.
module rv32_if_id_reg
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] inst_p0,
    input  logic [31:0] pc_p0,
    output logic        vld_p1,
    output logic [31:0] inst_p1,
    output logic [31:0] pc_p1,
    output logic [31:0] pc4_p1
);

    // Stage p0 -> p1: flush only clears valid, so the payload stays stable for debug visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            inst_p1 <= RV32_NOP;
            pc_p1   <= 32'h0;
            pc4_p1  <= 32'h0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            inst_p1 <= inst_p0;
            pc_p1   <= pc_p0;
            pc4_p1  <= pc_p0 + 32'd4;
        end
    end

endmodule

// File: rtl/rv32_fetch.sv
// RV32I instruction-fetch stage: owns the PC, drives the combinational instruction memory,
// and feeds decode through the IF/ID register; misaligned redirect targets park the stage in FAULT.
module rv32_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RV32_RESET_PC
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic [31:0] IMEM_A,
    output logic        IMEM_EN,
    input  logic [31:0] IMEM_RD,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        ID_READY,
    output logic        IF_VALID,
    output logic [31:0] IF_INST,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC4,
    output logic        IF_FAULT,
    output logic [31:0] FETCH_CNT
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_p0, pc_nxt;
    logic [31:0]  fetch_cnt;
    logic         advance;
    logic         load;
    logic         flush;
    logic         vld_p1;

    assign advance = (state == RUN) && (!vld_p1 || ID_READY);

    // A redirect always wins, even over a pending accept by decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        load      = 1'b0;
        flush     = 1'b0;
        if (REDIRECT) begin
            pc_nxt    = REDIRECT_PC;
            flush     = 1'b1;
            state_nxt = (REDIRECT_PC[1:0] != 2'b00) ? FAULT : RUN;
        end else begin
            case (state)
                BOOT: state_nxt = RUN;
                RUN: begin
                    if (advance) begin
                        load   = 1'b1;
                        pc_nxt = pc_p0 + 32'd4;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Stage p0: PC, FSM and fetch counter.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= BOOT;
            pc_p0     <= RESET_PC;
            fetch_cnt <= 32'h0;
        end else begin
            state <= state_nxt;
            pc_p0 <= pc_nxt;
            if (load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    // Stage p0 -> p1 boundary.
    rv32_if_id_reg u_if_id (
        .clk     (CLK),
        .rst_n   (RSTn),
        .load    (load),
        .flush   (flush),
        .inst_p0 (IMEM_RD),
        .pc_p0   (pc_p0),
        .vld_p1  (vld_p1),
        .inst_p1 (IF_INST),
        .pc_p1   (IF_PC),
        .pc4_p1  (IF_PC4)
    );

    assign IMEM_A    = pc_p0;
    assign IMEM_EN   = advance;
    assign IF_VALID  = vld_p1;
    assign IF_FAULT  = (state == FAULT);
    assign FETCH_CNT = fetch_cnt;

endmodule

// File: tb/tb_rv32_fetch.sv
// Self-checking bench for rv32_fetch: directed scenarios plus randomized traffic against a reference model.
module tb_rv32_fetch;
    import rv32_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RSTn;
    logic [31:0] imem_a, imem_rd, redirect_pc, if_inst, if_pc, if_pc4, fetch_cnt;
    logic        imem_en, redirect, id_ready, if_valid, if_fault;

    logic [31:0] imem_a_w, imem_rd_w, if_inst_w, if_pc_w, if_pc4_w, fetch_cnt_w;
    logic        imem_en_w, if_valid_w, if_fault_w;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd16) return 32'hA0 + (a >> 2);
        return a ^ 32'h5EED_0000;
    endfunction

    assign imem_rd   = mem_word(imem_a);
    assign imem_rd_w = mem_word(imem_a_w);

    rv32_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RSTn(RSTn), .IMEM_A(imem_a), .IMEM_EN(imem_en), .IMEM_RD(imem_rd),
        .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .ID_READY(id_ready),
        .IF_VALID(if_valid), .IF_INST(if_inst), .IF_PC(if_pc), .IF_PC4(if_pc4),
        .IF_FAULT(if_fault), .FETCH_CNT(fetch_cnt)
    );

    rv32_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RSTn(RSTn), .IMEM_A(imem_a_w), .IMEM_EN(imem_en_w), .IMEM_RD(imem_rd_w),
        .REDIRECT(1'b0), .REDIRECT_PC(32'h0), .ID_READY(1'b1),
        .IF_VALID(if_valid_w), .IF_INST(if_inst_w), .IF_PC(if_pc_w), .IF_PC4(if_pc4_w),
        .IF_FAULT(if_fault_w), .FETCH_CNT(fetch_cnt_w)
    );

    // Reference model: the next fetch address, the decode-facing entry and the fetch count.
    typedef struct packed {
        logic        boot;
        logic        fault;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] cnt;
    } model_t;

    localparam model_t MODEL_RST = '{boot: 1'b1, fault: 1'b0, valid: 1'b0, pc: 32'h0,
                                     inst: RV32_NOP, ifpc: 32'h0, ifpc4: 32'h0, cnt: 32'h0};
    model_t m;

    function automatic model_t model_next(input model_t cur, input logic redir,
                                          input logic [31:0] rpc, input logic rdy);
        model_t n = cur;
        if (redir) begin
            n.pc    = rpc;
            n.valid = 1'b0;
            n.fault = (rpc[1:0] != 2'b00);
            n.boot  = 1'b0;
        end else if (cur.boot) begin
            n.boot = 1'b0;
        end else if (!cur.fault && (!cur.valid || rdy)) begin
            n.inst  = mem_word(cur.pc);
            n.ifpc  = cur.pc;
            n.ifpc4 = cur.pc + 32'd4;
            n.valid = 1'b1;
            n.pc    = cur.pc + 32'd4;
            n.cnt   = cur.cnt + 32'd1;
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) m <= MODEL_RST;
        else       m <= model_next(m, redirect, redirect_pc, id_ready);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt, imem_en} !==
            {1'b0, RV32_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: valid=%b inst=%h pc=%h pc4=%h fault=%b cnt=%0d en=%b, required 0/00000013/0/0/0/0/0",
                     if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt, imem_en);
        end
        RSTn = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            errors++;
            $display("FAIL boot_en: imem_en=%b required 0", imem_en);
        end
        tick();
        checks++;
        if ({if_valid, imem_en, imem_a} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_fetch: valid=%b en=%b a=%h required 0/1/00000000", if_valid, imem_en, imem_a);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({if_valid, if_inst, if_pc} !== {1'b1, 32'hA0 + 32'(k), 32'(4 * k)}) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b inst=%h pc=%h required 1/%h/%h",
                         k, if_valid, if_inst, if_pc, 32'hA0 + 32'(k), 32'(4 * k));
            end
        end
        checks++;
        if (fetch_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stream_cnt: fetch_cnt=%0d required 3", fetch_cnt);
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        #1;
        checks++;
        if (imem_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_en: imem_en=%b required 0", imem_en);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({if_valid, if_inst, if_pc, fetch_cnt, imem_en} !== {1'b1, 32'hA2, 32'h8, 32'd3, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b inst=%h pc=%h cnt=%0d en=%b required 1/a2/8/3/0",
                         k, if_valid, if_inst, if_pc, fetch_cnt, imem_en);
            end
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if ({if_inst, if_pc, fetch_cnt} !== {32'hA3, 32'hC, 32'd4}) begin
            errors++;
            $display("FAIL stall_release: inst=%h pc=%h cnt=%0d required a3/c/4", if_inst, if_pc, fetch_cnt);
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        checks++;
        if ({if_valid, fetch_cnt, imem_a} !== {1'b0, 32'd4, 32'h40}) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b cnt=%0d a=%h required 0/4/40", if_valid, fetch_cnt, imem_a);
        end
        tick();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h required 1/40/%h", if_valid, if_pc, if_inst, mem_word(32'h40));
        end
        id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        checks++;
        if ({if_valid, fetch_cnt} !== {1'b0, 32'd5}) begin
            errors++;
            $display("FAIL redirect_vs_ready: valid=%b cnt=%0d required 0/5", if_valid, fetch_cnt);
        end
        tick();
        checks++;
        if ({if_valid, if_pc, fetch_cnt} !== {1'b1, 32'h100, 32'd6}) begin
            errors++;
            $display("FAIL redirect_vs_ready_target: valid=%b pc=%h cnt=%0d required 1/100/6", if_valid, if_pc, fetch_cnt);
        end
    endtask

    task automatic test_fault();
        redirect = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({if_fault, if_valid, imem_en, fetch_cnt} !== {1'b1, 1'b0, 1'b0, m.cnt}) begin
                errors++;
                $display("FAIL fault_hold_%0d: fault=%b valid=%b en=%b cnt=%0d required 1/0/0/%0d",
                         k, if_fault, if_valid, imem_en, fetch_cnt, m.cnt);
            end
            tick();
        end
        redirect = 1'b1; redirect_pc = 32'h45;
        tick();
        redirect = 1'b0;
        checks++;
        if ({if_fault, imem_a, imem_en} !== {1'b1, 32'h45, 1'b0}) begin
            errors++;
            $display("FAIL fault_misaligned_again: fault=%b a=%h en=%b required 1/45/0", if_fault, imem_a, imem_en);
        end
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        checks++;
        if ({if_fault, if_valid, imem_en} !== {1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fault_exit: fault=%b valid=%b en=%b required 0/0/1", if_fault, if_valid, imem_en);
        end
        tick();
        checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h80, mem_word(32'h80)}) begin
            errors++;
            $display("FAIL fault_refetch: valid=%b pc=%h inst=%h required 1/80/%h", if_valid, if_pc, if_inst, mem_word(32'h80));
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rpc = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = rpc;
            id_ready    = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if ({imem_en, imem_a} !== {!m.boot && !m.fault && (!m.valid || id_ready), m.pc}) begin
                errors++;
                $display("FAIL rand_imem cycle %0d: en=%b a=%h required %b/%h",
                         i, imem_en, imem_a, !m.boot && !m.fault && (!m.valid || id_ready), m.pc);
            end
            tick();
            checks++;
            if ({if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt} !==
                {m.valid, m.inst, m.ifpc, m.ifpc4, m.fault, m.cnt}) begin
                errors++;
                $display("FAIL rand_ifid cycle %0d: got %b/%h/%h/%h/%b/%0d required %b/%h/%h/%h/%b/%0d",
                         i, if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt,
                         m.valid, m.inst, m.ifpc, m.ifpc4, m.fault, m.cnt);
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h20; id_ready = 1'b1;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt, imem_en, imem_a} !==
            {1'b0, RV32_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: valid=%b inst=%h pc=%h pc4=%h fault=%b cnt=%0d en=%b a=%h",
                     if_valid, if_inst, if_pc, if_pc4, if_fault, fetch_cnt, imem_en, imem_a);
        end
        tick();
        RSTn = 1'b1;
        tick();
        checks++;
        if ({if_valid, imem_en} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_boot: valid=%b en=%b required 0/1", if_valid, imem_en);
        end
        tick();
        checks++;
        if ({if_valid, if_pc, if_inst, fetch_cnt} !== {1'b1, 32'h0, 32'hA0, 32'd1}) begin
            errors++;
            $display("FAIL async_reset_restart: valid=%b pc=%h inst=%h cnt=%0d required 1/0/a0/1",
                     if_valid, if_pc, if_inst, fetch_cnt);
        end
    endtask

    task automatic test_wrap();
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
        checks++;
        if ({imem_a_w, imem_en_w} !== {32'hFFFF_FFFC, 1'b1}) begin
            errors++;
            $display("FAIL wrap_first_addr: a=%h en=%b required fffffffc/1", imem_a_w, imem_en_w);
        end
        tick();
        checks++;
        if ({if_valid_w, if_pc_w, if_pc4_w, if_inst_w} !== {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
            errors++;
            $display("FAIL wrap_top: valid=%b pc=%h pc4=%h inst=%h required 1/fffffffc/0/%h",
                     if_valid_w, if_pc_w, if_pc4_w, if_inst_w, mem_word(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if ({if_pc_w, if_pc4_w, if_inst_w, fetch_cnt_w} !== {32'h0, 32'h4, 32'hA0, 32'd2}) begin
            errors++;
            $display("FAIL wrap_zero: pc=%h pc4=%h inst=%h cnt=%0d required 0/4/a0/2",
                     if_pc_w, if_pc4_w, if_inst_w, fetch_cnt_w);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_fault();
        test_random();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
